// File: rtl/keypad_scanner_pkg.sv
// Shared constants, types and helpers for the 4x3 keypad scanner.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_POS  = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = 10;

  // Marker for matrix positions that never report a digit (* and #).
  localparam logic [3:0] KEY_IGN = 4'hF;

  // Position -> digit table, position = col*NUM_ROWS + row.
  // Written highest position first: col2 {#,9,6,3}, col1 {0,8,5,2}, col0 {*,7,4,1}.
  localparam logic [NUM_POS-1:0][3:0] KEY_MAP = {
    KEY_IGN, 4'd9, 4'd6, 4'd3,
    4'd0,    4'd8, 4'd5, 4'd2,
    KEY_IGN, 4'd7, 4'd4, 4'd1
  };

  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [NUM_POS-1:0] snap_t;

  typedef enum logic [1:0] {
    KEYS_NONE,
    KEYS_ONE,
    KEYS_MULTI
  } key_class_e;

  // Fold a raw 12-position snapshot into the 10-bit digit vector.
  function automatic key_t map_keys(input snap_t snap);
    key_t k;
    k = '0;
    for (int p = 0; p < NUM_POS; p++) begin
      if (snap[p] && (KEY_MAP[p] != KEY_IGN)) k[KEY_MAP[p]] = 1'b1;
    end
    return k;
  endfunction

  // Popcount reduced to the three cases the commit logic cares about.
  function automatic key_class_e classify(input key_t k);
    int n;
    n = 0;
    for (int i = 0; i < KEY_W; i++) begin
      if (k[i]) n++;
    end
    if (n == 0) return KEYS_NONE;
    if (n == 1) return KEYS_ONE;
    return KEYS_MULTI;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debouncer: compares each completed scan's candidate with the
// previous one, commits after DEBOUNCE_SCANS identical scans and produces
// the key_valid pulse and multi_key level.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       scan_done,
  input  key_t       cand,
  output key_t       keypad,
  output logic       key_valid,
  output logic       multi_key
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  typedef logic [SW-1:0] stab_t;
  localparam stab_t STAB_MAX = stab_t'(DEBOUNCE_SCANS);

  stab_t      stable;
  stab_t      stable_nxt;
  key_t       prev;
  logic       pend;
  key_class_e cls;

  assign cls = classify(cand);

  // Next stable count: grow (saturating) on a repeat, restart at 1 on change.
  always_comb begin
    stable_nxt = stab_t'(1);
    if (cand == prev) begin
      stable_nxt = (stable == STAB_MAX) ? STAB_MAX : stable + stab_t'(1);
    end
  end

  // Debounce state, committed outputs, and the one-cycle-delayed valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable    <= '0;
      prev      <= '0;
      pend      <= 1'b0;
      keypad    <= '0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
    end else if (freeze) begin
      // Forcing stable to 0 means a full debounce is needed after resume.
      stable    <= '0;
      pend      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= pend;
      pend      <= 1'b0;
      if (scan_done) begin
        stable <= stable_nxt;
        prev   <= cand;
        if (stable_nxt == STAB_MAX) begin
          case (cls)
            KEYS_ONE: begin
              keypad    <= cand;
              multi_key <= 1'b0;
              pend      <= (cand != keypad);
            end
            KEYS_MULTI: begin
              keypad    <= '0;
              multi_key <= 1'b1;
            end
            default: begin
              keypad    <= '0;
              multi_key <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 membrane keypad scanner: drives one column low at a time, samples the
// rows on the last dwell cycle, assembles a full-matrix snapshot and hands
// each completed scan to the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enablen,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [KEY_W-1:0]    keypad,
  output logic                key_valid,
  output logic                multi_key
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [1:0]     COL_LAST = 2'(NUM_COLS - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    col;
  snap_t         snap;
  snap_t         snap_now;
  logic          last;
  logic          scan_done;
  key_t          cand;

  assign last = (cnt == CNT_LAST);

  // Column drive: one line low while scanning, all released while disabled.
  always_comb begin
    cols_n = '1;
    if (!enablen) cols_n[col] = 1'b0;
  end

  // Snapshot with the current column's rows merged in, so the map sees the
  // column-2 sample on the same edge it is captured.
  always_comb begin
    snap_now = snap;
    snap_now[col*NUM_ROWS +: NUM_ROWS] = ~rows_n;
  end

  // Dwell counter, column pointer, snapshot capture and scan-complete strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      col       <= '0;
      snap      <= '0;
      scan_done <= 1'b0;
      cand      <= '0;
    end else if (enablen) begin
      // Parked at column 0 so scanning resumes with a clean first column.
      cnt       <= '0;
      col       <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (last) begin
        cnt  <= '0;
        snap <= snap_now;
        if (col == COL_LAST) begin
          col       <= '0;
          scan_done <= 1'b1;
          cand      <= map_keys(snap_now);
        end else begin
          col <= col + 2'd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .freeze   (enablen),
    .scan_done(scan_done),
    .cand     (cand),
    .keypad   (keypad),
    .key_valid(key_valid),
    .multi_key(multi_key)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A small matrix model turns the pressed[row][col] array into rows_n.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enablen = 1'b0;
  logic [3:0] rows_n;
  logic [2:0] cols_n;
  logic [9:0] keypad;
  logic       key_valid;
  logic       multi_key;

  logic [3:0][2:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int bb_cnt = 0;
  logic kv_prev = 1'b0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enablen  (enablen),
    .rows_n   (rows_n),
    .cols_n   (cols_n),
    .keypad   (keypad),
    .key_valid(key_valid),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Row r is pulled low when a pressed key in row r sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) rows_n[r] = ~|(pressed[r] & ~cols_n);
  end

  // Count key_valid pulses and any back-to-back highs.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_cnt <= kv_cnt + 1;
      if (kv_prev) bb_cnt <= bb_cnt + 1;
    end
    kv_prev <= (key_valid === 1'b1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where reset is released (reference cycle 0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    pressed = '0;
    enablen = 1'b0;
    rst = 1'b0;
    wait_cyc(2);
    checks++; if (cols_n !== 3'b110) begin errors++; $display("FAIL reset_cols got %b exp 110", cols_n); end
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL reset_keypad got %h exp 000", keypad); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b exp 0", key_valid); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_mk got %b exp 0", multi_key); end
  endtask

  task automatic test_idle_scan();
    int k0;
    logic [2:0] e;
    pressed = '0;
    do_reset();
    k0 = kv_cnt;
    for (int i = 0; i < 36; i++) begin
      e = 3'b111;
      e[(i / 4) % 3] = 1'b0;
      checks++; if (cols_n !== e) begin errors++; $display("FAIL idle_cols cyc %0d got %b exp %b", i, cols_n, e); end
      @(negedge clk);
    end
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL idle_keypad got %h exp 000", keypad); end
    checks++; if (kv_cnt != k0) begin errors++; $display("FAIL idle_kv pulses %0d exp 0", kv_cnt - k0); end
  endtask

  task automatic test_single_key();
    int k0;
    pressed = '0;
    pressed[1][1] = 1'b1;
    do_reset();
    k0 = kv_cnt;
    wait_cyc(36);
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL k5_early got %h exp 000", keypad); end
    wait_cyc(1);
    checks++; if (keypad !== 10'h020) begin errors++; $display("FAIL k5_commit got %h exp 020", keypad); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL k5_kv_early got %b exp 0", key_valid); end
    wait_cyc(1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL k5_kv got %b exp 1", key_valid); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL k5_mk got %b exp 0", multi_key); end
    wait_cyc(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL k5_kv_width got %b exp 0", key_valid); end
    wait_cyc(21);
    checks++; if (keypad !== 10'h020) begin errors++; $display("FAIL k5_held got %h exp 020", keypad); end
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL k5_pulses got %0d exp 1", kv_cnt - k0); end
    pressed = '0;
    wait_cyc(40);
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL k5_release got %h exp 000", keypad); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL k5_rel_mk got %b exp 0", multi_key); end
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL k5_rel_pulses got %0d exp 1", kv_cnt - k0); end
  endtask

  task automatic test_bounce();
    int k0;
    pressed = '0;
    do_reset();
    k0 = kv_cnt;
    // Scan 1 samples pressed, scan 2 samples released, then held from cycle 24.
    for (int i = 0; i < 24; i++) begin
      pressed[3][1] = (((i + 1) / 5) % 2 == 1);
      @(negedge clk);
    end
    pressed[3][1] = 1'b1;
    wait_cyc(36);
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL bounce_early got %h exp 000", keypad); end
    wait_cyc(1);
    checks++; if (keypad !== 10'h001) begin errors++; $display("FAIL bounce_commit got %h exp 001", keypad); end
    wait_cyc(10);
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", kv_cnt - k0); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL bounce_mk got %b exp 0", multi_key); end
  endtask

  task automatic test_multi_key();
    int k0;
    k0 = kv_cnt;
    pressed = '0;
    pressed[0][0] = 1'b1;
    pressed[2][2] = 1'b1;
    wait_cyc(60);
    checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_mk got %b exp 1", multi_key); end
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL multi_keypad got %h exp 000", keypad); end
    checks++; if (kv_cnt != k0) begin errors++; $display("FAIL multi_pulses got %0d exp 0", kv_cnt - k0); end
    pressed[2][2] = 1'b0;
    wait_cyc(60);
    checks++; if (keypad !== 10'h002) begin errors++; $display("FAIL multi_rel_keypad got %h exp 002", keypad); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_rel_mk got %b exp 0", multi_key); end
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL multi_rel_pulses got %0d exp 1", kv_cnt - k0); end
  endtask

  task automatic test_ignored_keys();
    int k0;
    k0 = kv_cnt;
    pressed = '0;
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    wait_cyc(60);
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL ign_keypad got %h exp 000", keypad); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL ign_mk got %b exp 0", multi_key); end
    checks++; if (kv_cnt != k0) begin errors++; $display("FAIL ign_pulses got %0d exp 0", kv_cnt - k0); end
  endtask

  task automatic test_enable_freeze();
    int k0;
    pressed = '0;
    pressed[2][1] = 1'b1;
    do_reset();
    wait_cyc(40);
    checks++; if (keypad !== 10'h100) begin errors++; $display("FAIL frz_k8 got %h exp 100", keypad); end
    // Key 3 seen for two scans (stable=2) before the freeze.
    pressed = '0;
    pressed[0][2] = 1'b1;
    wait_cyc(22);
    k0 = kv_cnt;
    enablen = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (cols_n !== 3'b111) begin errors++; $display("FAIL frz_cols cyc %0d got %b exp 111", i, cols_n); end
      checks++; if (keypad !== 10'h100) begin errors++; $display("FAIL frz_keypad cyc %0d got %h exp 100", i, keypad); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL frz_kv cyc %0d got %b exp 0", i, key_valid); end
      @(negedge clk);
    end
    enablen = 1'b0;
    #1;
    checks++; if (cols_n !== 3'b110) begin errors++; $display("FAIL frz_resume_cols got %b exp 110", cols_n); end
    wait_cyc(36);
    checks++; if (keypad !== 10'h100) begin errors++; $display("FAIL frz_early got %h exp 100", keypad); end
    wait_cyc(1);
    checks++; if (keypad !== 10'h008) begin errors++; $display("FAIL frz_commit got %h exp 008", keypad); end
    wait_cyc(1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL frz_kv_after got %b exp 1", key_valid); end
    wait_cyc(5);
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL frz_pulses got %0d exp 1", kv_cnt - k0); end
  endtask

  task automatic test_reset_mid_scan();
    int k0;
    pressed = '0;
    pressed[2][0] = 1'b1;
    wait_cyc(60);
    checks++; if (keypad !== 10'h080) begin errors++; $display("FAIL rst7_pre got %h exp 080", keypad); end
    wait_cyc(5);
    rst = 1'b0;
    #1;
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL rst7_keypad got %h exp 000", keypad); end
    checks++; if (cols_n !== 3'b110) begin errors++; $display("FAIL rst7_cols got %b exp 110", cols_n); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst7_kv got %b exp 0", key_valid); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL rst7_mk got %b exp 0", multi_key); end
    @(negedge clk);
    rst = 1'b1;
    k0 = kv_cnt;
    wait_cyc(36);
    checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL rst7_early got %h exp 000", keypad); end
    wait_cyc(1);
    checks++; if (keypad !== 10'h080) begin errors++; $display("FAIL rst7_commit got %h exp 080", keypad); end
    wait_cyc(1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rst7_kv_after got %b exp 1", key_valid); end
    wait_cyc(7);
    checks++; if (kv_cnt - k0 != 1) begin errors++; $display("FAIL rst7_pulses got %0d exp 1", kv_cnt - k0); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_ignored_keys();
    test_enable_freeze();
    test_reset_mid_scan();
    checks++; if (bb_cnt != 0) begin errors++; $display("FAIL kv_back_to_back got %0d exp 0", bb_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the microwave's 4x3 membrane keypad matrix and produces the debounced one-hot `keypad[9:0]` bus the keypad input encoder consumes. Drives the column lines one at a time, samples the row lines, debounces over whole scans, and reports one clean key per press. Sits at the pins, between the physical keypad and the encoder that turns `keypad` into digit/load.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles each column stays driven (≥2).
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to commit a change (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enablen` in 1: active-low scan enable; high freezes scanning.
- `rows_n` in 4: row lines, active-low (pulled up externally), row0..row3.
- `cols_n` out 3: column drive, active-low, exactly one low while scanning.
- `keypad` out 10: debounced one-hot key level, bit i = digit i held; all-zero = none.
- `key_valid` out 1: one-cycle pulse when `keypad` commits to a new nonzero value.
- `multi_key` out 1: level, high while committed scan shows more than one digit key.

## Operation
- Key map (row,col): (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6, (2,0)=7, (2,1)=8, (2,2)=9, (3,1)=0. (3,0) and (3,2) (`*`, `#`) are ignored everywhere, including `multi_key`.
- Dwell counter counts 0..SCAN_DIV-1 per column. On the terminal-count cycle: capture `~rows_n` into that column's slot of a 12-bit raw snapshot, advance column 0→1→2→0, restart counter.
- After the column-2 capture, the snapshot maps to a 10-bit candidate (scan complete).
- Debounce per scan complete: candidate == previous candidate → stable count +1, saturating at DEBOUNCE_SCANS; else stable count = 1, previous = candidate.
- Commit when stable count reaches DEBOUNCE_SCANS (and on every later stable scan):
  - zero bits set: `keypad`=0, `multi_key`=0.
  - one bit set: `keypad`=candidate, `multi_key`=0.
  - two or more bits set: `keypad`=0, `multi_key`=1.
- `key_valid` pulses on the cycle after a commit that changes `keypad` to a nonzero value different from its prior value. Includes a direct A→B change without an intervening release. Never pulses on release or while held.
- `enablen` high: counter and column pointer hold, `cols_n`=3'b111, snapshot/debounce state held, `keypad`/`multi_key` hold, `key_valid`=0. On return low: restart at column 0, counter 0, stable count 0. Committed outputs keep their values until the next commit.

## Timing
- Reset (async assert, sync release): `cols_n`=3'b110, counter 0, column 0, stable count 0, previous candidate 0, `keypad`=0, `key_valid`=0, `multi_key`=0.
- One full scan = 3·SCAN_DIV cycles. `rows_n` for column c is sampled on the last dwell cycle, giving SCAN_DIV-1 cycles of settling.
- Press-to-`key_valid` latency: a press stable from scan start commits at the end of scan DEBOUNCE_SCANS. `keypad` updates 1 cycle after the column-2 capture. `key_valid` follows 1 cycle later. Worst case adds one partial scan.
- `key_valid` is registered: exactly one cycle high, never back-to-back.
- Bounce shorter than one scan resets the stable count. No output change until DEBOUNCE_SCANS clean scans.
- Reset mid-scan: all state returns to reset values immediately, and no pulse is emitted.

## Structure
- Shared package: NUM_ROWS=4, NUM_COLS=3, key-map constant (12-entry position→digit table with ignore marker), `keypad` width 10.
- One sub-module, `keypad_debounce`: candidate compare, stable counter, commit, popcount, `key_valid`/`multi_key` generation.
- Top level holds the dwell counter, column pointer, snapshot and map.

## Test plan
(SCAN_DIV=4, DEBOUNCE_SCANS=3 unless noted.)
- Reset then idle with `rows_n`=4'hF: `cols_n` cycles 110→101→011 every 4 cycles; `keypad`=0, `key_valid` never high.
- Hold key 5 (row1 low only while col1 driven) for 5 scans: `keypad`=10'h020 after the 3rd scan, `key_valid` one pulse, `multi_key`=0. Release for 3 scans: `keypad`=0 with no pulse.
- Key 0 (row3/col1) with bounce toggling every 5 cycles for 2 scans, then held: commit only 3 clean scans after the bounce ends; exactly one `key_valid`; `keypad`=10'h001.
- Keys 1 and 9 held together: `multi_key`=1, `keypad`=0, no pulse. Release 9: `keypad`=10'h002, one pulse, `multi_key`=0.
- `*` and `#` held alone: `keypad`=0, `multi_key`=0. `enablen` high mid-scan: `cols_n`=3'b111 and outputs frozen. On return low, scanning restarts at col0 and a full 3-scan debounce is required.
- Assert `rst` while key 7 is committed mid-scan: all outputs go to reset values immediately. After release with key 7 still held, one new `key_valid` follows after 3 scans.
